// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: receive side of the 4:1 TDM selection path.
// Collects four consecutive slot beats (slot 0 flagged by in_sof) into shadow
// registers and commits them to out0..out3 together, on the edge that samples
// the slot-3 beat. A frame restarted early by in_sof is dropped and counted.
module tdm_demux_4ch #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_valid,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       slot
);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] shadow0_q, shadow0_d;
  logic [WIDTH-1:0] shadow1_q, shadow1_d;
  logic [WIDTH-1:0] shadow2_q, shadow2_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic [WIDTH-1:0] out3_q, out3_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // State register: IDLE until a start-of-frame beat arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: sof opens a frame, the slot-3 beat closes it; early sof stays in RECV.
  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      case (state_q)
        IDLE: begin
          if (in_sof) begin
            state_d = RECV;
          end
        end
        RECV: begin
          if (!in_sof && (slot_q == 2'd3)) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values: shadow capture, commit on slot 3, error pulse and saturating count.
  always_comb begin
    slot_d      = slot_q;
    shadow0_d   = shadow0_q;
    shadow1_d   = shadow1_q;
    shadow2_d   = shadow2_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    out2_d      = out2_q;
    out3_d      = out3_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (in_valid) begin
      if (state_q == IDLE) begin
        if (in_sof) begin
          shadow0_d = in_data;
          slot_d    = 2'd1;
        end
      end else if (in_sof) begin
        frame_err_d = 1'b1;
        if (err_cnt_q != CNT_MAX) begin
          err_cnt_d = err_cnt_q + CNT_ONE;
        end
        shadow0_d = in_data;
        slot_d    = 2'd1;
      end else begin
        case (slot_q)
          2'd1: begin
            shadow1_d = in_data;
            slot_d    = 2'd2;
          end
          2'd2: begin
            shadow2_d = in_data;
            slot_d    = 2'd3;
          end
          2'd3: begin
            out0_d      = shadow0_q;
            out1_d      = shadow1_q;
            out2_d      = shadow2_q;
            out3_d      = in_data;
            out_valid_d = 1'b1;
            slot_d      = 2'd0;
          end
          default: slot_d = slot_q;
        endcase
      end
    end
  end

  // Datapath registers: everything returns to zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q      <= 2'd0;
      shadow0_q   <= '0;
      shadow1_q   <= '0;
      shadow2_q   <= '0;
      out0_q      <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
      out3_q      <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      slot_q      <= slot_d;
      shadow0_q   <= shadow0_d;
      shadow1_q   <= shadow1_d;
      shadow2_q   <= shadow2_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      out3_q      <= out3_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out0      = out0_q;
  assign out1      = out1_q;
  assign out2      = out2_q;
  assign out3      = out3_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;
  assign slot      = slot_q;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed bench for tdm_demux_4ch. A second instance with CNT_W=2 shares the
// same stimulus so counter saturation can be observed.
module tb_tdm_demux_4ch;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_data;

  logic [7:0] out0, out1, out2, out3;
  logic       out_valid, frame_err;
  logic [7:0] err_cnt;
  logic [1:0] slot;

  logic [7:0] s_out0, s_out1, s_out2, s_out3;
  logic       s_out_valid, s_frame_err;
  logic [1:0] s_err_cnt;
  logic [1:0] s_slot;

  int checkCount = 0;
  int errorCount = 0;

  tdm_demux_4ch #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .frame_err(frame_err), .err_cnt(err_cnt), .slot(slot)
  );

  tdm_demux_4ch #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .out0(s_out0), .out1(s_out1), .out2(s_out2), .out3(s_out3),
    .out_valid(s_out_valid), .frame_err(s_frame_err), .err_cnt(s_err_cnt), .slot(s_slot)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one beat (or an idle cycle when valid=0) across one rising edge,
  // returning 1 ns after the edge with in_valid low.
  task automatic applyStimulus(input logic valid, input logic sof, input logic [7:0] data);
    in_valid = valid;
    in_sof   = sof;
    in_data  = data;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    checkOutput({tag, "_out0"}, 32'(out0), 32'(e0));
    checkOutput({tag, "_out1"}, 32'(out1), 32'(e1));
    checkOutput({tag, "_out2"}, 32'(out2), 32'(e2));
    checkOutput({tag, "_out3"}, 32'(out3), 32'(e3));
  endtask

  task automatic syncReset();
    rst = 1'b1;
    idleCycles(2);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = 8'h00;
    idleCycles(2);

    // Reset state.
    checkFrame("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("rst_valid", 32'(out_valid), 0);
    checkOutput("rst_err", 32'(frame_err), 0);
    checkOutput("rst_cnt", 32'(err_cnt), 0);
    checkOutput("rst_slot", 32'(slot), 0);
    rst = 1'b0;

    // One frame on consecutive cycles.
    applyStimulus(1'b1, 1'b1, 8'h11);
    checkOutput("f1_slot1", 32'(slot), 1);
    checkOutput("f1_valid1", 32'(out_valid), 0);
    applyStimulus(1'b1, 1'b0, 8'h22);
    checkOutput("f1_slot2", 32'(slot), 2);
    applyStimulus(1'b1, 1'b0, 8'h33);
    checkOutput("f1_slot3", 32'(slot), 3);
    checkOutput("f1_noleak", 32'(out0), 0);
    applyStimulus(1'b1, 1'b0, 8'h44);
    checkOutput("f1_valid", 32'(out_valid), 1);
    checkOutput("f1_slot0", 32'(slot), 0);
    checkFrame("f1", 8'h11, 8'h22, 8'h33, 8'h44);
    idleCycles(1);
    checkOutput("f1_pulse", 32'(out_valid), 0);
    checkOutput("f1_hold", 32'(out2), 'h33);

    // Gapped frame: previous outputs hold until the last beat.
    applyStimulus(1'b1, 1'b1, 8'h61);
    idleCycles(2);
    checkOutput("gap_hold0", 32'(out0), 'h11);
    checkOutput("gap_slot", 32'(slot), 1);
    applyStimulus(1'b1, 1'b0, 8'h62);
    idleCycles(2);
    applyStimulus(1'b1, 1'b0, 8'h63);
    idleCycles(2);
    checkOutput("gap_hold3", 32'(out3), 'h44);
    checkOutput("gap_novalid", 32'(out_valid), 0);
    applyStimulus(1'b1, 1'b0, 8'h64);
    checkOutput("gap_valid", 32'(out_valid), 1);
    checkFrame("gap", 8'h61, 8'h62, 8'h63, 8'h64);
    idleCycles(1);
    checkOutput("gap_pulse", 32'(out_valid), 0);

    // Early sof aborts the A frame; the B frame is delivered.
    applyStimulus(1'b1, 1'b1, 8'hA0);
    applyStimulus(1'b1, 1'b0, 8'hA1);
    applyStimulus(1'b1, 1'b1, 8'hB0);
    checkOutput("esof_err", 32'(frame_err), 1);
    checkOutput("esof_cnt", 32'(err_cnt), 1);
    checkOutput("esof_novalid", 32'(out_valid), 0);
    checkOutput("esof_slot", 32'(slot), 1);
    checkOutput("esof_hold", 32'(out0), 'h61);
    applyStimulus(1'b1, 1'b0, 8'hB1);
    checkOutput("esof_errpulse", 32'(frame_err), 0);
    applyStimulus(1'b1, 1'b0, 8'hB2);
    applyStimulus(1'b1, 1'b0, 8'hB3);
    checkOutput("esof_valid", 32'(out_valid), 1);
    checkOutput("esof_noerr", 32'(frame_err), 0);
    checkFrame("esof", 8'hB0, 8'hB1, 8'hB2, 8'hB3);
    checkOutput("esof_cnt_hold", 32'(err_cnt), 1);

    // Stray beats in IDLE are ignored silently.
    applyStimulus(1'b1, 1'b0, 8'h55);
    checkOutput("stray_err", 32'(frame_err), 0);
    checkOutput("stray_slot", 32'(slot), 0);
    applyStimulus(1'b1, 1'b0, 8'h66);
    checkOutput("stray_valid", 32'(out_valid), 0);
    applyStimulus(1'b1, 1'b1, 8'h71);
    applyStimulus(1'b1, 1'b0, 8'h72);
    applyStimulus(1'b1, 1'b0, 8'h73);
    applyStimulus(1'b1, 1'b0, 8'h74);
    checkOutput("stray_fvalid", 32'(out_valid), 1);
    checkFrame("stray", 8'h71, 8'h72, 8'h73, 8'h74);
    checkOutput("stray_cnt", 32'(err_cnt), 1);

    // Back-to-back frame directly after the slot-3 beat.
    applyStimulus(1'b1, 1'b1, 8'h81);
    checkOutput("b2b_slot", 32'(slot), 1);
    checkOutput("b2b_err", 32'(frame_err), 0);
    applyStimulus(1'b1, 1'b0, 8'h82);
    applyStimulus(1'b1, 1'b0, 8'h83);
    applyStimulus(1'b1, 1'b0, 8'h84);
    checkFrame("b2b", 8'h81, 8'h82, 8'h83, 8'h84);

    // Saturation: five early-sof aborts after a fresh reset.
    syncReset();
    applyStimulus(1'b1, 1'b1, 8'hC0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'hC0 + i));
      checkOutput($sformatf("sat_err%0d", i), 32'(frame_err), 1);
      checkOutput($sformatf("sat_cnt8_%0d", i), 32'(err_cnt), 32'(i));
      checkOutput($sformatf("sat_cnt2_%0d", i), 32'(s_err_cnt), 32'((i < 3) ? i : 3));
    end
    applyStimulus(1'b1, 1'b0, 8'hD2);
    applyStimulus(1'b1, 1'b0, 8'hD3);
    applyStimulus(1'b1, 1'b0, 8'hD4);
    checkFrame("sat", 8'hC5, 8'hD2, 8'hD3, 8'hD4);
    checkOutput("sat_valid", 32'(out_valid), 1);

    // Asynchronous reset between slot 1 and slot 2.
    applyStimulus(1'b1, 1'b1, 8'hE0);
    #3;
    rst = 1'b1;
    #1;
    checkFrame("arst", 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("arst_cnt", 32'(err_cnt), 0);
    checkOutput("arst_slot", 32'(slot), 0);
    idleCycles(1);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'hE1);
    applyStimulus(1'b1, 1'b0, 8'hE2);
    applyStimulus(1'b1, 1'b0, 8'hE3);
    checkOutput("arst_novalid", 32'(out_valid), 0);
    checkOutput("arst_out3", 32'(out3), 0);
    checkOutput("arst_noerr", 32'(frame_err), 0);
    applyStimulus(1'b1, 1'b1, 8'hF1);
    applyStimulus(1'b1, 1'b0, 8'hF2);
    applyStimulus(1'b1, 1'b0, 8'hF3);
    applyStimulus(1'b1, 1'b0, 8'hF4);
    checkOutput("arst_valid", 32'(out_valid), 1);
    checkFrame("arst_f", 8'hF1, 8'hF2, 8'hF3, 8'hF4);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
